ahb_burst_master: RTL
=====================

AHB_BURST_MASTER -- requirements
Module: ahb_burst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, bus data width (32 or 64).
REQ-003 SHALL have parameter BEATS, default 4, beats per block (AES block = 128 bits / DATA_W).
REQ-004 SHALL have parameter CNT_W, default 16, block-count width.
REQ-005 SHALL have one clock and an asynchronous active-high reset: hclk input 1, rising-edge clock; hrst input 1, asynchronous active-high reset.
REQ-006 SHALL have these control ports: start input 1, one-cycle job request; mode input 1, 0=read, 1=write; base_addr input ADDR_W, first byte address; num_blocks input CNT_W, blocks in the job.
REQ-007 SHALL have these AHB-Lite ports: hready input 1; hresp input 1; hrdata input DATA_W; haddr output ADDR_W; htrans output 2; hwrite output 1; hsize output 3; hburst output 3; hwdata output DATA_W.
REQ-008 SHALL have these stream ports: rd_data output DATA_W; rd_valid output 1; wr_data input DATA_W; wr_req output 1, pop strobe; busy output 1; block_done output 1; done output 1; error output 1.

Function
REQ-009 SHALL sample base_addr, num_blocks and mode when start=1 in IDLE, and ignore start in any other state.
REQ-010 SHALL pulse done for one cycle the cycle after start when num_blocks=0, with no bus transfer.
REQ-011 SHALL implement the states IDLE, ADDR, BURST, DRAIN and ERR.
REQ-012 SHALL move IDLE->ADDR on an accepted start with num_blocks!=0.
REQ-013 SHALL move ADDR->BURST on the first hready=1.
REQ-014 SHALL move BURST->DRAIN when the last address of the last block is accepted.
REQ-015 SHALL move DRAIN->IDLE when the last data phase completes.
REQ-016 SHALL move any active state->ERR on an error response.
REQ-017 SHALL move ERR->IDLE on the next cycle.
REQ-018 SHALL drive htrans: NONSEQ(2'b10) on the first beat of each block, SEQ(2'b11) on later beats, IDLE(2'b00) in IDLE, DRAIN and ERR.
REQ-019 SHALL drive hsize=log2(DATA_W/8), and hburst=INCR4(3'b011) when BEATS=4, INCR(3'b001) otherwise.
REQ-020 SHALL hold haddr, htrans and hwrite stable while hready=0.
REQ-021 SHALL advance the beat or block only on cycles with hready=1.
REQ-022 SHALL compute beat address = base + (blk*BEATS + beat)*(DATA_W/8), modulo 2^ADDR_W; wrap-around is silent.
REQ-023 SHALL overlap address phase of beat n with data phase of beat n-1 (pipelined, zero-wait throughput one beat/cycle).
REQ-024 SHALL, in write mode, assert wr_req for one cycle when an address phase is accepted, and register wr_data into hwdata for the matching data phase; hwdata SHALL hold while hready=0.
REQ-025 SHALL, in read mode, assert rd_valid with rd_data=hrdata in each data-phase cycle with hready=1 and hresp=0.
REQ-026 SHALL pulse block_done for one cycle when the last data phase of each block completes.
REQ-027 SHALL pulse done together with the final block_done.
REQ-028 SHALL detect an error on hresp=1 with hready=0 (first error cycle): drive htrans=IDLE on the following cycle, cancel all remaining beats, and issue no further wr_req or rd_valid.
REQ-029 SHALL, in ERR, pulse error and done together for one cycle.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL treat simultaneous hresp=1 and the last-beat data phase as an error, with no block_done.

Reset
REQ-032 SHALL, on hrst=1 at any time including mid-burst, immediately force state IDLE, haddr=0, htrans=IDLE, hwrite=0, hwdata=0, rd_data=0, and all strobes (rd_valid, wr_req, block_done, done, error)=0, and busy=0.
REQ-033 SHALL leave hsize and hburst at their parameter-derived constants during reset.
REQ-034 SHALL perform no transfer after reset release until a new start.

Verification
REQ-035 SHALL cover a read, 1 block, base 0x1000, hready=1 -> haddr 0x1000/04/08/0C, htrans 10,11,11,11; 4 rd_valid; block_done and done in the cycle of the 4th rd_valid.
REQ-036 SHALL cover a write, 2 blocks, base 0x2000, slave inserts 2 wait states on beat 2 -> 8 wr_req, haddr 0x2000..0x201C, NONSEQ at 0x2000 and 0x2010, hwdata stable through waits.
REQ-037 SHALL cover num_blocks=0 -> done one cycle after start, htrans stays IDLE.
REQ-038 SHALL cover an error on beat 3 of block 1 -> htrans=IDLE the next cycle, error and done pulse, no block_done, busy drops.
REQ-039 SHALL cover hrst asserted mid-burst of a 3-block read -> all outputs reset the same cycle, no transfer until a new start.
REQ-040 SHALL cover base 0xFFFFFFF8, write 1 block -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.

Source files
------------

// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: moves num_blocks blocks of BEATS beats between the bus and a
// word stream, with pipelined address/data phases and two-cycle error-response abort.
module ahb_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_blocks,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_req,
  output logic              busy,
  output logic              block_done,
  output logic              done,
  output logic              error
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [2:0] HSIZE  = 3'($clog2(BYTES));
  localparam logic [2:0] HBURST = (BEATS == 4) ? 3'b011 : 3'b001;
  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ERR} state_t;

  state_t state, state_nxt;

  logic              mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  nblk_q;
  logic [CNT_W-1:0]  blk_q;
  logic [BW-1:0]     beat_q;
  logic              dp_valid;
  logic              dp_last_beat;
  logic              dp_last_blk;
  logic              zero_done_q;

  logic addr_phase;
  logic accept;
  logic last_beat_addr;
  logic last_addr;
  logic err_det;
  logic dp_done;

  assign hsize  = HSIZE;
  assign hburst = HBURST;

  assign addr_phase     = (state == S_ADDR) || (state == S_BURST);
  assign accept         = addr_phase && hready;
  assign last_beat_addr = (beat_q == LAST_BEAT);
  assign last_addr      = last_beat_addr && (blk_q == nblk_q - CNT_W'(1));
  // Any hresp during an outstanding data phase aborts, whether or not hready is already high.
  assign err_det        = dp_valid && hresp;
  assign dp_done        = dp_valid && hready && !hresp;

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && (num_blocks != '0)) state_nxt = S_ADDR;
      S_ADDR:  if (hready) state_nxt = last_addr ? S_DRAIN : S_BURST;
      S_BURST: begin
        if (err_det)                 state_nxt = S_ERR;
        else if (hready && last_addr) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (err_det)     state_nxt = S_ERR;
        else if (hready) state_nxt = S_IDLE;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    htrans     = TR_IDLE;
    haddr      = '0;
    hwrite     = 1'b0;
    busy       = (state != S_IDLE);
    wr_req     = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    block_done = 1'b0;
    done       = 1'b0;
    error      = (state == S_ERR);
    case (state)
      S_ADDR:  htrans = TR_NONSEQ;
      S_BURST: htrans = (beat_q == '0) ? TR_NONSEQ : TR_SEQ;
      default: htrans = TR_IDLE;
    endcase
    if (addr_phase) begin
      haddr  = addr_q;
      hwrite = mode_q;
    end
    wr_req     = accept && mode_q && !err_det;
    rd_valid   = dp_done && !mode_q;
    rd_data    = rd_valid ? hrdata : '0;
    block_done = dp_done && dp_last_beat;
    done       = (block_done && dp_last_blk) || zero_done_q || (state == S_ERR);
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      mode_q       <= 1'b0;
      addr_q       <= '0;
      nblk_q       <= '0;
      blk_q        <= '0;
      beat_q       <= '0;
      hwdata       <= '0;
      dp_valid     <= 1'b0;
      dp_last_beat <= 1'b0;
      dp_last_blk  <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      zero_done_q <= (state == S_IDLE) && start && (num_blocks == '0);
      if ((state == S_IDLE) && start) begin
        mode_q <= mode;
        addr_q <= base_addr;
        nblk_q <= num_blocks;
        blk_q  <= '0;
        beat_q <= '0;
      end
      if (accept) begin
        addr_q <= addr_q + ADDR_W'(BYTES);
        if (last_beat_addr) begin
          beat_q <= '0;
          blk_q  <= blk_q + CNT_W'(1);
        end else begin
          beat_q <= beat_q + BW'(1);
        end
        if (mode_q) hwdata <= wr_data;
      end
      // The data-phase tracker only moves on hready, so it stalls with the slave.
      if (err_det) begin
        dp_valid <= 1'b0;
      end else if (hready) begin
        dp_valid     <= accept;
        dp_last_beat <= last_beat_addr;
        dp_last_blk  <= last_addr;
      end
    end
  end

endmodule
